// File: rtl/sync_bus_arbiter_pkg.sv
// Shared constants and state encoding for the synchronizer front end.
// Defaults are shared with the data_synchronizer instantiation beside the arbiter.
package sync_bus_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_NUM_REQ     = 4;
    localparam int DEFAULT_HOLD_CYCLES = 4;
    localparam int DEFAULT_GAP_CYCLES  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, wrapping modulo NUM_REQ. Produces a one-hot grant and its index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int         cand;
    logic [IDX_W-1:0] cand_idx;
    logic       found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(pointer) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/sync_bus_arbiter.sv
// Source-domain front end that time-shares one synchronizer channel between
// NUM_REQ requesters: capture, one setup cycle, HOLD_CYCLES enable, GAP_CYCLES quiet.
module sync_bus_arbiter
    import sync_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         unsync_bus,
    output logic                          bus_enable,
    output logic                          busy,
    output state_t                        dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);

    // Handshake: requester i raises req[i] with its word stable on req_data and
    // holds both until ack[i] is high (a one-cycle capture pulse); it drops req[i]
    // the following cycle, otherwise a further transfer is requested. Dropping
    // req[i] before ack[i] withdraws the request.

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [IDX_W-1:0]      ptr, ptr_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic [NUM_REQ-1:0]    ack_n;
    logic                  en_n;

    logic [DATA_WIDTH-1:0] words [NUM_REQ];
    logic [NUM_REQ-1:0]    win_grant;
    logic [IDX_W-1:0]      win_idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req),
        .pointer   (ptr),
        .grant     (win_grant),
        .grant_idx (win_idx)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= IDX_W'(NUM_REQ - 1);
            unsync_bus <= '0;
            ack        <= '0;
            bus_enable <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            unsync_bus <= data_n;
            ack        <= ack_n;
            bus_enable <= en_n;
        end
    end

    // bus_enable is registered, so it is decided one state ahead of the cycle it covers.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        data_n  = unsync_bus;
        ack_n   = '0;
        en_n    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    data_n  = words[win_idx];
                    ack_n   = win_grant;
                    ptr_n   = win_idx;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                state_n = HOLD;
                cnt_n   = '0;
                en_n    = 1'b1;
            end
            HOLD: begin
                if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    en_n  = 1'b1;
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_sync_bus_arbiter.sv
// Self-checking bench for sync_bus_arbiter: scenario tasks plus a scoreboard
// that pops the expected word on every rising edge of bus_enable.
module tb_sync_bus_arbiter;
    import sync_bus_arbiter_pkg::*;

    localparam int NR     = 4;
    localparam int DW     = 8;
    localparam int HOLD_N = 4;
    localparam int GAP_N  = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [DW-1:0]     word [NR];
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     ack;
    logic [DW-1:0]     unsync_bus;
    logic              bus_enable;
    logic              busy;
    state_t            dbg_state;

    logic [DW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mdl_ptr = NR - 1;

    assign req_data = {word[3], word[2], word[1], word[0]};

    sync_bus_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .HOLD_CYCLES(HOLD_N), .GAP_CYCLES(GAP_N)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_data(req_data), .ack(ack),
        .unsync_bus(unsync_bus), .bus_enable(bus_enable), .busy(busy),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // scoreboard: each enable pulse must carry the next expected word, stay
    // stable while high and last exactly HOLD_N cycles
    logic          prev_en = 1'b0;
    int            en_len = 0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] exp_w;

    always @(negedge CLK) begin
        if (!RST) begin
            prev_en = 1'b0;
            en_len  = 0;
        end else begin
            if (bus_enable && !prev_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_enable got bus %h want no transfer", unsync_bus);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (unsync_bus !== exp_w) begin
                        errors++;
                        $display("FAIL sb_word got %h want %h", unsync_bus, exp_w);
                    end
                end
                held = unsync_bus;
            end
            if (bus_enable) begin
                en_len++;
                checks++;
                if (unsync_bus !== held) begin
                    errors++;
                    $display("FAIL sb_stable got %h want %h", unsync_bus, held);
                end
            end
            if (!bus_enable && prev_en) begin
                checks++;
                if (en_len != HOLD_N) begin
                    errors++;
                    $display("FAIL sb_enable_len got %0d want %0d", en_len, HOLD_N);
                end
                en_len = 0;
            end
            prev_en = bus_enable;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int exp_winner(input logic [NR-1:0] m, input int p);
        for (int k = 1; k <= NR; k++) begin
            if (m[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic test_reset();
        word[0] = 8'h11; word[1] = 8'h22; word[2] = 8'h33; word[3] = 8'h44;
        req = 4'b1111;
        RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({ack, unsync_bus, bus_enable, busy} !== '0 || dbg_state !== IDLE) begin
                errors++;
                $display("FAIL reset_outputs got ack=%b bus=%h en=%b busy=%b st=%0d want all 0",
                         ack, unsync_bus, bus_enable, busy, dbg_state);
            end
        end
        exp_q.push_back(8'h11);
        RST = 1'b1;
        tick();
        checks++;
        if (ack !== 4'b0001 || unsync_bus !== 8'h11) begin
            errors++;
            $display("FAIL reset_first_ack got ack=%b bus=%h want ack=0001 bus=11", ack, unsync_bus);
        end
        req = '0;
        mdl_ptr = 0;
        for (int n = 0; n < 40 && busy; n++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_single();
        int n;
        word[2] = 8'hAA;
        req = 4'b0100;
        exp_q.push_back(8'hAA);
        n = 0;
        while (ack == '0 && n < 40) begin tick(); n++; end
        checks++;
        if (ack !== 4'b0100) begin
            errors++;
            $display("FAIL single_ack got %b want 0100", ack);
        end
        req = '0;
        mdl_ptr = 2;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus_enable !== (i >= 1 && i <= 4)) begin
                errors++;
                $display("FAIL single_enable cycle %0d got %b want %b", i, bus_enable, (i >= 1 && i <= 4));
            end
            checks++;
            if (unsync_bus !== 8'hAA) begin
                errors++;
                $display("FAIL single_bus cycle %0d got %h want aa", i, unsync_bus);
            end
            if (i > 0) begin
                checks++;
                if (ack !== '0) begin
                    errors++;
                    $display("FAIL single_ack_pulse cycle %0d got %b want 0000", i, ack);
                end
            end
            if (i == 7) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL single_busy got %b want 0", busy);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] pend;
        int order [NR];
        int n, last_cyc, p;
        RST = 1'b0;
        tick();
        RST = 1'b1;
        mdl_ptr = NR - 1;
        word[0] = 8'h10; word[1] = 8'h21; word[2] = 8'h32; word[3] = 8'h43;
        pend = 4'b1111;
        p = mdl_ptr;
        for (int k = 0; k < NR; k++) begin
            order[k] = exp_winner(pend, p);
            pend[order[k]] = 1'b0;
            p = order[k];
            exp_q.push_back(word[order[k]]);
        end
        req = 4'b1111;
        last_cyc = 0;
        for (int k = 0; k < NR; k++) begin
            if (k > 0) tick();
            n = 0;
            while (ack == '0 && n < 40) begin tick(); n++; end
            checks++;
            if (ack !== (4'b0001 << order[k]) || unsync_bus !== word[order[k]]) begin
                errors++;
                $display("FAIL rr_ack%0d got ack=%b bus=%h want ack=%b bus=%h",
                         k, ack, unsync_bus, 4'b0001 << order[k], word[order[k]]);
            end
            if (k > 0) begin
                checks++;
                if (cyc - last_cyc != 8) begin
                    errors++;
                    $display("FAIL rr_spacing%0d got %0d want 8", k, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            req[order[k]] = 1'b0;
        end
        mdl_ptr = order[NR-1];
        for (int i = 0; i < 40 && busy; i++) tick();
    endtask

    task automatic test_fairness_wrap();
        int n, c0;
        word[0] = 8'h5A; word[3] = 8'hC3;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        req = 4'b1001;
        n = 0;
        while (ack == '0 && n < 40) begin tick(); n++; end
        checks++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_first got %b want 0001", ack);
        end
        c0 = cyc;
        tick();
        n = 0;
        while (ack == '0 && n < 40) begin tick(); n++; end
        checks++;
        if (ack !== 4'b1000 || unsync_bus !== 8'hC3 || cyc - c0 != 8) begin
            errors++;
            $display("FAIL wrap_second got ack=%b bus=%h gap=%0d want ack=1000 bus=c3 gap=8",
                     ack, unsync_bus, cyc - c0);
        end
        req = '0;
        mdl_ptr = 3;
        for (int i = 0; i < 40 && busy; i++) tick();
    endtask

    task automatic test_stability();
        int n;
        word[1] = 8'hF0;
        req = 4'b0010;
        exp_q.push_back(8'hF0);
        n = 0;
        while (ack == '0 && n < 40) begin tick(); n++; end
        checks++;
        if (ack !== 4'b0010) begin
            errors++;
            $display("FAIL stab_ack got %b want 0010", ack);
        end
        req = '0;
        mdl_ptr = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                for (int j = 0; j < NR; j++) word[j] = 8'hFF;
                req = 4'b0001;
            end
            if (i == 5) req = '0;
            checks++;
            if (unsync_bus !== 8'hF0 || (i > 0 && ack !== '0)) begin
                errors++;
                $display("FAIL stab_hold cycle %0d got bus=%h ack=%b want bus=f0 ack=0000",
                         i, unsync_bus, ack);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stab_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        word[3] = 8'h77;
        req = 4'b1000;
        exp_q.push_back(8'h77);
        n = 0;
        while (ack == '0 && n < 40) begin tick(); n++; end
        checks++;
        if (ack !== (4'b0001 << exp_winner(4'b1000, mdl_ptr))) begin
            errors++;
            $display("FAIL mid_first_ack got %b want 1000", ack);
        end
        req = '0;
        tick();
        tick();
        checks++;
        if (bus_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_hold got en=%b want 1", bus_enable);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (bus_enable !== 1'b0 || unsync_bus !== '0 || ack !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset got en=%b bus=%h ack=%b busy=%b want all 0",
                     bus_enable, unsync_bus, ack, busy);
        end
        tick();
        RST = 1'b1;
        mdl_ptr = NR - 1;
        word[1] = 8'h3C;
        req = 4'b0010;
        exp_q.push_back(8'h3C);
        n = 0;
        while (ack == '0 && n < 40) begin tick(); n++; end
        checks++;
        if (ack !== 4'b0010 || unsync_bus !== 8'h3C) begin
            errors++;
            $display("FAIL mid_fresh got ack=%b bus=%h want ack=0010 bus=3c", ack, unsync_bus);
        end
        req = '0;
        mdl_ptr = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (ack !== '0) begin
                errors++;
                $display("FAIL mid_no_reack cycle %0d got %b want 0000", i, ack);
            end
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] pend;
        int order [NR];
        int cnt, p, n;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < NR; j++) word[j] = DW'($urandom_range(0, 255));
            pend = NR'($urandom_range(1, 15));
            req = pend;
            cnt = 0;
            p = mdl_ptr;
            while (pend != '0) begin
                order[cnt] = exp_winner(pend, p);
                pend[order[cnt]] = 1'b0;
                p = order[cnt];
                exp_q.push_back(word[order[cnt]]);
                cnt++;
            end
            for (int k = 0; k < cnt; k++) begin
                if (k > 0) tick();
                n = 0;
                while (ack == '0 && n < 40) begin tick(); n++; end
                checks++;
                if (ack !== (4'b0001 << order[k])) begin
                    errors++;
                    $display("FAIL rand_r%0d_k%0d got %b want %b", r, k, ack, 4'b0001 << order[k]);
                end
                req[order[k]] = 1'b0;
            end
            mdl_ptr = order[cnt-1];
            for (int i = 0; i < 40 && busy; i++) tick();
        end
    endtask

    initial begin
        for (int j = 0; j < NR; j++) word[j] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness_wrap();
        test_stability();
        test_mid_reset();
        test_random();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
